// File: rtl/reg_bus_pkg.sv
// Shared constants and FSM encoding for the register-bus initiator.
package reg_bus_pkg;

  localparam int ADDR_W = 4;
  localparam int DATA_W = 8;
  localparam logic [ADDR_W-1:0] IDLE_ADDR = 4'hF;

  typedef enum logic [2:0] {
    IDLE,
    SETUP,
    STROBE,
    WAIT,
    RESP
  } state_t;

  localparam logic [ADDR_W-1:0] REG0 = 4'd0;
  localparam logic [ADDR_W-1:0] REG1 = 4'd1;
  localparam logic [ADDR_W-1:0] REG2 = 4'd2;
  localparam logic [ADDR_W-1:0] REG3 = 4'd3;

endpackage

// File: rtl/reg_bus_wait_ctr.sv
// Read-latency down-counter: loaded on strobe exit, done in the last WAIT cycle.
module reg_bus_wait_ctr #(
  parameter int READ_LAT = 1
) (
  input  logic clk,
  input  logic rst,
  input  logic load,
  input  logic run,
  output logic done
);

  logic [1:0] cnt;

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt <= 2'd0;
    end else if (load) begin
      cnt <= 2'(READ_LAT - 1);
    end else if (run && cnt != 2'd0) begin
      cnt <= cnt - 2'd1;
    end
  end

  assign done = run && (cnt == 2'd0);

endmodule

// File: rtl/reg_bus_initiator.sv
// Single-outstanding register-bus initiator with setup/strobe/capture sequencing
// and an optional read-back compare with saturating mismatch count.
module reg_bus_initiator #(
  parameter int                ADDR_W    = reg_bus_pkg::ADDR_W,
  parameter int                DATA_W    = reg_bus_pkg::DATA_W,
  parameter logic [ADDR_W-1:0] IDLE_ADDR = reg_bus_pkg::IDLE_ADDR,
  parameter int                READ_LAT  = 1,
  parameter int                CNT_W     = 16
) (
  input  logic              clk,
  input  logic              resetb,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic              cmd_write,
  input  logic [ADDR_W-1:0] cmd_addr,
  input  logic [DATA_W-1:0] cmd_wdata,
  input  logic              cmd_check,
  input  logic [DATA_W-1:0] cmd_expected,
  output logic              resp_valid,
  input  logic              resp_ready,
  output logic              resp_write,
  output logic [DATA_W-1:0] resp_rdata,
  output logic              resp_mismatch,
  output logic [CNT_W-1:0]  mismatch_cnt,
  output logic [ADDR_W-1:0] address,
  output logic              write_en,
  output logic              read_en,
  output logic [DATA_W-1:0] data_in,
  input  logic [DATA_W-1:0] read_data
);

  import reg_bus_pkg::*;

  if (READ_LAT < 1 || READ_LAT > 4) begin : g_bad_read_lat
    $error("reg_bus_initiator: READ_LAT must be in 1..4");
  end

  state_t state, state_nxt;

  logic              cmd_write_p0;
  logic [ADDR_W-1:0] cmd_addr_p0;
  logic [DATA_W-1:0] cmd_wdata_p0;
  logic              cmd_check_p0;
  logic [DATA_W-1:0] cmd_expected_p0;

  logic accept;
  logic resp_done;
  logic wait_done;
  logic rd_mismatch;

  // Commands are refused while reset is held so garbage on cmd_* cannot slip in.
  assign cmd_ready   = (state == IDLE) && !resetb;
  assign accept      = cmd_valid && cmd_ready;
  assign resp_done   = resp_valid && resp_ready;
  assign rd_mismatch = cmd_check_p0 && (read_data !== cmd_expected_p0);

  reg_bus_wait_ctr #(
    .READ_LAT(READ_LAT)
  ) u_wait_ctr (
    .clk (clk),
    .rst (resetb),
    .load(state == STROBE && !cmd_write_p0),
    .run (state == WAIT),
    .done(wait_done)
  );

  always_ff @(posedge clk) begin
    if (resetb) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (accept) state_nxt = SETUP;
      SETUP:   state_nxt = STROBE;
      STROBE:  state_nxt = cmd_write_p0 ? RESP : WAIT;
      WAIT:    if (wait_done) state_nxt = RESP;
      RESP:    if (resp_done) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Stage p0: command capture at the accept edge
  always_ff @(posedge clk) begin
    if (accept) begin
      cmd_write_p0    <= cmd_write;
      cmd_addr_p0     <= cmd_addr;
      cmd_wdata_p0    <= cmd_wdata;
      cmd_check_p0    <= cmd_check;
      cmd_expected_p0 <= cmd_expected;
    end
  end

  // Bus drive and response capture
  always_ff @(posedge clk) begin
    if (resetb) begin
      address       <= IDLE_ADDR;
      write_en      <= 1'b0;
      read_en       <= 1'b0;
      data_in       <= '0;
      resp_valid    <= 1'b0;
      resp_write    <= 1'b0;
      resp_rdata    <= '0;
      resp_mismatch <= 1'b0;
      mismatch_cnt  <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) address <= cmd_addr;
        end
        SETUP: begin
          address  <= cmd_addr_p0;
          write_en <= cmd_write_p0;
          read_en  <= !cmd_write_p0;
          if (cmd_write_p0) data_in <= cmd_wdata_p0;
        end
        STROBE: begin
          write_en <= 1'b0;
          read_en  <= 1'b0;
          address  <= IDLE_ADDR;
          data_in  <= '0;
          if (cmd_write_p0) begin
            resp_valid    <= 1'b1;
            resp_write    <= 1'b1;
            resp_rdata    <= '0;
            resp_mismatch <= 1'b0;
          end
        end
        WAIT: begin
          if (wait_done) begin
            resp_valid    <= 1'b1;
            resp_write    <= 1'b0;
            resp_rdata    <= read_data;
            resp_mismatch <= rd_mismatch;
            if (rd_mismatch && !(&mismatch_cnt)) mismatch_cnt <= mismatch_cnt + CNT_W'(1);
          end
        end
        RESP: begin
          if (resp_done) resp_valid <= 1'b0;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_reg_bus_initiator.sv
// Directed bench for reg_bus_initiator with a small behavioural register-file device.
module tb_reg_bus_initiator;
  import reg_bus_pkg::*;

  localparam int RL = 1;

  logic        clk;
  logic        resetb;
  logic        cmd_valid;
  logic        cmd_ready;
  logic        cmd_write;
  logic [3:0]  cmd_addr;
  logic [7:0]  cmd_wdata;
  logic        cmd_check;
  logic [7:0]  cmd_expected;
  logic        resp_valid;
  logic        resp_ready;
  logic        resp_write;
  logic [7:0]  resp_rdata;
  logic        resp_mismatch;
  logic [15:0] mismatch_cnt;
  logic [3:0]  address;
  logic        write_en;
  logic        read_en;
  logic [7:0]  data_in;
  logic [7:0]  read_data;

  int checks = 0;
  int errors = 0;

  reg_bus_initiator #(.READ_LAT(RL)) dut (
    .clk          (clk),
    .resetb       (resetb),
    .cmd_valid    (cmd_valid),
    .cmd_ready    (cmd_ready),
    .cmd_write    (cmd_write),
    .cmd_addr     (cmd_addr),
    .cmd_wdata    (cmd_wdata),
    .cmd_check    (cmd_check),
    .cmd_expected (cmd_expected),
    .resp_valid   (resp_valid),
    .resp_ready   (resp_ready),
    .resp_write   (resp_write),
    .resp_rdata   (resp_rdata),
    .resp_mismatch(resp_mismatch),
    .mismatch_cnt (mismatch_cnt),
    .address      (address),
    .write_en     (write_en),
    .read_en      (read_en),
    .data_in      (data_in),
    .read_data    (read_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Device: four registers resetting to 10..13, registered read port (one cycle).
  logic [7:0] dev_regs [4];
  always @(posedge clk) begin
    if (resetb) begin
      for (int i = 0; i < 4; i++) dev_regs[i] <= 8'h10 + 8'(i);
      read_data <= 8'h00;
    end else begin
      if (write_en && address < 4'd4) dev_regs[address[1:0]] <= data_in;
      if (read_en) read_data <= (address < 4'd4) ? dev_regs[address[1:0]] : 8'h00;
    end
  end

  typedef struct {
    logic        wr;
    logic [3:0]  addr;
    logic [7:0]  wdata;
    logic        chk;
    logic [7:0]  expd;
    logic [7:0]  rdata;
    logic        mis;
    logic [15:0] cnt;
  } vec_t;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic run_cmd(input vec_t v, input int hold);
    int n;
    cmd_valid    = 1'b1;
    cmd_write    = v.wr;
    cmd_addr     = v.addr;
    cmd_wdata    = v.wdata;
    cmd_check    = v.chk;
    cmd_expected = v.expd;
    resp_ready   = (hold == 0);
    n = 0;
    while (!cmd_ready && n < 100) begin
      @(posedge clk); #1;
      n++;
    end
    chk("cmd_ready_wait", 32'(cmd_ready), 32'd1);
    @(posedge clk); #1;
    // Scramble cmd_* after the accept edge: the initiator must use its latched copy.
    cmd_valid    = 1'b0;
    cmd_write    = ~v.wr;
    cmd_addr     = ~v.addr;
    cmd_wdata    = ~v.wdata;
    cmd_check    = ~v.chk;
    cmd_expected = ~v.expd;
    chk("setup_addr", 32'(address), 32'(v.addr));
    chk("setup_we", 32'(write_en), 32'd0);
    chk("setup_re", 32'(read_en), 32'd0);
    chk("setup_cmd_ready", 32'(cmd_ready), 32'd0);
    @(posedge clk); #1;
    chk("strobe_we", 32'(write_en), 32'(v.wr));
    chk("strobe_re", 32'(read_en), 32'(!v.wr));
    chk("strobe_addr", 32'(address), 32'(v.addr));
    chk("strobe_din", 32'(data_in), v.wr ? 32'(v.wdata) : 32'd0);
    @(posedge clk); #1;
    chk("post_we", 32'(write_en), 32'd0);
    chk("post_re", 32'(read_en), 32'd0);
    chk("post_addr", 32'(address), 32'hF);
    chk("post_din", 32'(data_in), 32'd0);
    if (!v.wr) begin
      for (int i = 0; i < RL; i++) begin
        chk("wait_resp_valid", 32'(resp_valid), 32'd0);
        @(posedge clk); #1;
      end
    end
    chk("resp_valid", 32'(resp_valid), 32'd1);
    chk("resp_write", 32'(resp_write), 32'(v.wr));
    chk("resp_rdata", 32'(resp_rdata), 32'(v.rdata));
    chk("resp_mismatch", 32'(resp_mismatch), 32'(v.mis));
    chk("mismatch_cnt", 32'(mismatch_cnt), 32'(v.cnt));
    for (int i = 0; i < hold; i++) begin
      @(posedge clk); #1;
      chk("hold_resp_valid", 32'(resp_valid), 32'd1);
      chk("hold_rdata", 32'(resp_rdata), 32'(v.rdata));
      chk("hold_mismatch", 32'(resp_mismatch), 32'(v.mis));
      chk("hold_cmd_ready", 32'(cmd_ready), 32'd0);
      chk("hold_strobes", {30'd0, write_en, read_en}, 32'd0);
    end
    resp_ready = 1'b1;
    @(posedge clk); #1;
    chk("resp_drop", 32'(resp_valid), 32'd0);
    chk("idle_cmd_ready", 32'(cmd_ready), 32'd1);
  endtask

  vec_t vecs [14];
  vec_t v;

  initial begin
    // wr, addr, wdata, chk, expd, exp rdata, exp mis, exp cnt
    vecs[0]  = '{1'b1, REG0, 8'hA5, 1'b0, 8'h00, 8'h00, 1'b0, 16'd0};
    vecs[1]  = '{1'b0, REG0, 8'h00, 1'b1, 8'hA5, 8'hA5, 1'b0, 16'd0};
    vecs[2]  = '{1'b1, REG1, 8'hA6, 1'b0, 8'h00, 8'h00, 1'b0, 16'd0};
    vecs[3]  = '{1'b1, REG2, 8'hA7, 1'b0, 8'h00, 8'h00, 1'b0, 16'd0};
    vecs[4]  = '{1'b1, REG3, 8'hA8, 1'b1, 8'h3C, 8'h00, 1'b0, 16'd0};
    vecs[5]  = '{1'b0, REG0, 8'h00, 1'b1, 8'hA5, 8'hA5, 1'b0, 16'd0};
    vecs[6]  = '{1'b0, REG1, 8'h00, 1'b1, 8'hA6, 8'hA6, 1'b0, 16'd0};
    vecs[7]  = '{1'b0, REG2, 8'h00, 1'b1, 8'hA7, 8'hA7, 1'b0, 16'd0};
    vecs[8]  = '{1'b0, REG3, 8'h00, 1'b1, 8'hA8, 8'hA8, 1'b0, 16'd0};
    vecs[9]  = '{1'b0, REG0, 8'h00, 1'b0, 8'h00, 8'hA5, 1'b0, 16'd0};
    vecs[10] = '{1'b0, REG2, 8'h00, 1'b1, 8'h00, 8'hA7, 1'b1, 16'd1};
    vecs[11] = '{1'b0, REG2, 8'h00, 1'b0, 8'h00, 8'hA7, 1'b0, 16'd1};
    vecs[12] = '{1'b0, REG3, 8'h00, 1'b1, 8'hA8, 8'hA8, 1'b0, 16'd1};
    vecs[13] = '{1'b1, REG1, 8'h5B, 1'b1, 8'hFF, 8'h00, 1'b0, 16'd1};

    resetb       = 1'b1;
    cmd_valid    = 1'b1;
    cmd_write    = 1'b1;
    cmd_addr     = 4'h2;
    cmd_wdata    = 8'hC3;
    cmd_check    = 1'b1;
    cmd_expected = 8'h99;
    resp_ready   = 1'b0;

    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      cmd_addr  = 4'($urandom);
      cmd_wdata = 8'($urandom);
      chk("rst_addr", 32'(address), 32'hF);
      chk("rst_strobes", {30'd0, write_en, read_en}, 32'd0);
      chk("rst_resp_valid", 32'(resp_valid), 32'd0);
      chk("rst_cmd_ready", 32'(cmd_ready), 32'd0);
    end
    chk("rst_resp_rdata", 32'(resp_rdata), 32'd0);
    chk("rst_mismatch_cnt", 32'(mismatch_cnt), 32'd0);
    chk("rst_data_in", 32'(data_in), 32'd0);
    resetb    = 1'b0;
    cmd_valid = 1'b0;
    @(posedge clk); #1;
    chk("release_cmd_ready", 32'(cmd_ready), 32'd1);
    chk("release_no_strobe", {30'd0, write_en, read_en}, 32'd0);

    for (int i = 0; i < 14; i++) run_cmd(vecs[i], 0);

    // Response back-pressure: consumer stalls for five cycles.
    v = '{1'b0, REG1, 8'h00, 1'b1, 8'h5B, 8'h5B, 1'b0, 16'd1};
    run_cmd(v, 5);

    // Reset lands during the STROBE cycle of a write to REG3.
    cmd_valid = 1'b1;
    cmd_write = 1'b1;
    cmd_addr  = REG3;
    cmd_wdata = 8'h5A;
    cmd_check = 1'b0;
    chk("mid_rst_ready", 32'(cmd_ready), 32'd1);
    @(posedge clk); #1;
    cmd_valid = 1'b0;
    @(posedge clk); #1;
    chk("mid_rst_strobe_on", 32'(write_en), 32'd1);
    resetb = 1'b1;
    @(posedge clk); #1;
    chk("mid_rst_we_drop", 32'(write_en), 32'd0);
    chk("mid_rst_addr", 32'(address), 32'hF);
    chk("mid_rst_resp_valid", 32'(resp_valid), 32'd0);
    chk("mid_rst_cnt", 32'(mismatch_cnt), 32'd0);
    resetb = 1'b0;
    @(posedge clk); #1;
    chk("after_rst_resp_valid", 32'(resp_valid), 32'd0);
    chk("after_rst_cmd_ready", 32'(cmd_ready), 32'd1);
    v = '{1'b0, REG3, 8'h00, 1'b1, 8'h13, 8'h13, 1'b0, 16'd0};
    run_cmd(v, 0);
    v = '{1'b0, REG0, 8'h00, 1'b1, 8'hA5, 8'h10, 1'b1, 16'd1};
    run_cmd(v, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not complete, checks %0d", checks);
    $fatal(1);
  end

endmodule
